// File: rtl/divfreq_prog_nch.sv
// divfreq_prog_nch: run-time programmable multi-channel clock divider on clock50.
// Each channel counts 0..div-1 and drives a near-50%-duty square wave. A new divisor
// is parked in a pending slot and only takes effect on a period boundary, or
// immediately while the channel is disabled, so the outputs never glitch.
// Optional feature macro: DIVFREQ_TICK_EN adds a per-channel tick output that
// pulses on every cnt==0 cycle of a running channel.
module divfreq_prog_nch #(
  parameter int NCH         = 2,
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 50000000,
  parameter int SEL_W       = 3
) (
  input  logic             clock50,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic             load,
  input  logic [SEL_W-1:0] load_sel,
  input  logic [CNT_W-1:0] load_div,
  output logic             load_ack,
  output logic             load_err,
  output logic [NCH-1:0]   clk_out
`ifdef DIVFREQ_TICK_EN
  ,
  output logic [NCH-1:0]   tick
`endif
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } chState_e;

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [SEL_W:0]   NCH_LIM = (SEL_W+1)'(NCH);

  logic                 loadValid;
  logic [NCH-1:0]       loadHit;
  logic                 loadAck_q, loadAck_d;
  logic                 loadErr_q, loadErr_d;

  chState_e             state_q  [NCH];
  chState_e             state_d  [NCH];
  logic [CNT_W-1:0]     cnt_q    [NCH];
  logic [CNT_W-1:0]     cnt_d    [NCH];
  logic [CNT_W-1:0]     div_q    [NCH];
  logic [CNT_W-1:0]     div_d    [NCH];
  logic [CNT_W-1:0]     pndDiv_q [NCH];
  logic [CNT_W-1:0]     pndDiv_d [NCH];
  logic [CNT_W:0]       hiCnt    [NCH];
  logic [NCH-1:0]       run_q, run_d;
  logic [NCH-1:0]       clkOut_q, clkOut_d;
  logic [NCH-1:0]       tick_q, tick_d;
  logic [NCH-1:0]       applyNow;

  // Decode the load request: it is accepted only for an existing channel and a
  // divisor of at least 2, and exactly one channel is selected when it is.
  always_comb begin
    loadValid = (load_div >= MIN_DIV) && ({1'b0, load_sel} < NCH_LIM);
    loadAck_d = load && loadValid;
    loadErr_d = load && !loadValid;
    loadHit   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (loadAck_d && (load_sel == SEL_W'(i))) begin
        loadHit[i] = 1'b1;
      end
    end
  end

  // Per-channel counter, pending-divisor state machine and output decode. A pending
  // divisor is consumed at a wrap or while disabled; a load arriving in that same
  // cycle refills the pending slot for the following boundary.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      div_d[i]    = div_q[i];
      pndDiv_d[i] = pndDiv_q[i];
      run_d[i]    = en[i];
      applyNow[i] = 1'b0;
      hiCnt[i]    = '0;
      clkOut_d[i] = 1'b0;
      tick_d[i]   = 1'b0;

      if (!en[i]) begin
        cnt_d[i]    = '0;
        applyNow[i] = 1'b1;
      end else if (!run_q[i]) begin
        cnt_d[i]    = '0;
      end else if (cnt_q[i] == (div_q[i] - ONE)) begin
        cnt_d[i]    = '0;
        applyNow[i] = 1'b1;
      end else begin
        cnt_d[i]    = cnt_q[i] + ONE;
      end

      case (state_q[i])
        RUN: begin
          if (loadHit[i]) begin
            state_d[i] = PEND;
          end
        end
        PEND: begin
          if (applyNow[i]) begin
            div_d[i]   = pndDiv_q[i];
            state_d[i] = loadHit[i] ? PEND : RUN;
          end
        end
        default: begin
          state_d[i] = RUN;
        end
      endcase

      if (loadHit[i]) begin
        pndDiv_d[i] = load_div;
      end

      hiCnt[i]    = ({1'b0, div_d[i]} + (CNT_W+1)'(1)) >> 1;
      clkOut_d[i] = en[i] && ({1'b0, cnt_d[i]} < hiCnt[i]);
      tick_d[i]   = en[i] && (cnt_d[i] == '0);
    end
  end

  // Channel state registers; reset restores the default divisor and drops any
  // pending reprogramming.
  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= RUN;
        cnt_q[i]    <= '0;
        div_q[i]    <= DEF_DIV;
        pndDiv_q[i] <= DEF_DIV;
      end
      run_q    <= '0;
      clkOut_q <= '0;
      tick_q   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= state_d[i];
        cnt_q[i]    <= cnt_d[i];
        div_q[i]    <= div_d[i];
        pndDiv_q[i] <= pndDiv_d[i];
      end
      run_q    <= run_d;
      clkOut_q <= clkOut_d;
      tick_q   <= tick_d;
    end
  end

  // Handshake response pulses, one cycle after the request.
  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      loadAck_q <= 1'b0;
      loadErr_q <= 1'b0;
    end else begin
      loadAck_q <= loadAck_d;
      loadErr_q <= loadErr_d;
    end
  end

  assign load_ack = loadAck_q;
  assign load_err = loadErr_q;
  assign clk_out  = clkOut_q;

`ifdef DIVFREQ_TICK_EN
  assign tick = tick_q;
`else
  logic unusedTick;
  assign unusedTick = ^tick_q;
`endif

endmodule

// File: tb/tb_divfreq_prog_nch.sv
// tb_divfreq_prog_nch: directed vector table plus hand-written sequences for the
// divisor reprogramming, last-load-wins and reset-while-pending corners.
module tb_divfreq_prog_nch;

  localparam int NCH   = 2;
  localparam int CNT_W = 8;
  localparam int DEF   = 4;
  localparam int SEL_W = 2;

  logic             clock50;
  logic             reset;
  logic [NCH-1:0]   en;
  logic             load;
  logic [SEL_W-1:0] load_sel;
  logic [CNT_W-1:0] load_div;
  logic             load_ack;
  logic             load_err;
  logic [NCH-1:0]   clk_out;
`ifdef DIVFREQ_TICK_EN
  logic [NCH-1:0]   tick;
`endif

  typedef struct {
    logic [1:0] en;
    logic       load;
    logic [1:0] sel;
    logic [7:0] div;
    logic       ack;
    logic       err;
    logic [1:0] clk;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  int   checkCount;
  int   passCount;
  logic expClk;
  logic ldNow;
  logic [7:0] ldDiv;

  divfreq_prog_nch #(
    .NCH(NCH),
    .CNT_W(CNT_W),
    .DEFAULT_DIV(DEF),
    .SEL_W(SEL_W)
  ) dut (
    .clock50(clock50),
    .reset(reset),
    .en(en),
    .load(load),
    .load_sel(load_sel),
    .load_div(load_div),
    .load_ack(load_ack),
    .load_err(load_err),
    .clk_out(clk_out)
`ifdef DIVFREQ_TICK_EN
    ,
    .tick(tick)
`endif
  );

  // Free-running 100 MHz-style clock.
  initial begin
    clock50 = 1'b0;
    forever #5 clock50 = ~clock50;
  end

  // Hard stop in case the sequence never finishes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t makeVec(input logic [1:0] e, input logic l, input logic [1:0] s,
                                   input logic [7:0] d, input logic a, input logic r,
                                   input logic [1:0] c);
    vec_t v;
    v.en = e; v.load = l; v.sel = s; v.div = d; v.ack = a; v.err = r; v.clk = c;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [1:0] e, input logic l, input logic [1:0] s,
                               input logic [7:0] d);
    @(negedge clock50);
    en       = e;
    load     = l;
    load_sel = s;
    load_div = d;
    @(posedge clock50);
    #1;
  endtask

  // Main sequence.
  initial begin
    checkCount = 0;
    passCount  = 0;
    reset      = 1'b1;
    en         = '0;
    load       = 1'b0;
    load_sel   = '0;
    load_div   = '0;

    vecs[0]  = makeVec(2'b00, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'b00);
    vecs[1]  = makeVec(2'b01, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'b01);
    vecs[2]  = makeVec(2'b01, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'b01);
    vecs[3]  = makeVec(2'b01, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'b00);
    vecs[4]  = makeVec(2'b01, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'b00);
    vecs[5]  = makeVec(2'b01, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'b01);
    vecs[6]  = makeVec(2'b01, 1'b1, 2'd3, 8'd5, 1'b0, 1'b1, 2'b01);
    vecs[7]  = makeVec(2'b01, 1'b1, 2'd0, 8'd1, 1'b0, 1'b1, 2'b00);
    vecs[8]  = makeVec(2'b01, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'b00);
    vecs[9]  = makeVec(2'b01, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'b01);
    vecs[10] = makeVec(2'b11, 1'b1, 2'd1, 8'd5, 1'b1, 1'b0, 2'b11);
    vecs[11] = makeVec(2'b11, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'b10);
    vecs[12] = makeVec(2'b11, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'b00);
    vecs[13] = makeVec(2'b11, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'b01);
    vecs[14] = makeVec(2'b11, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'b11);
    vecs[15] = makeVec(2'b11, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'b10);
    vecs[16] = makeVec(2'b11, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'b10);
    vecs[17] = makeVec(2'b11, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'b01);
    vecs[18] = makeVec(2'b11, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'b01);
    vecs[19] = makeVec(2'b11, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'b10);
    vecs[20] = makeVec(2'b00, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'b00);

    repeat (2) @(posedge clock50);
    #1;
    checkOutput("reset_clk", clk_out, 2'b00);
    checkOutput("reset_ack", load_ack, 1'b0);
    checkOutput("reset_err", load_err, 1'b0);
`ifdef DIVFREQ_TICK_EN
    checkOutput("reset_tick", tick, 2'b00);
`endif
    @(negedge clock50);
    reset = 1'b0;

    $display("[TB] vector table");
    for (int v = 0; v < NVEC; v++) begin
      applyStimulus(vecs[v].en, vecs[v].load, vecs[v].sel, vecs[v].div);
      checkOutput($sformatf("vec%0d_clk", v), clk_out, vecs[v].clk);
      checkOutput($sformatf("vec%0d_ack", v), load_ack, vecs[v].ack);
      checkOutput($sformatf("vec%0d_err", v), load_err, vecs[v].err);
    end

    $display("[TB] last load wins");
    applyStimulus(2'b00, 1'b1, 2'd0, 8'd10);
    checkOutput("lw_ack10", load_ack, 1'b1);
    applyStimulus(2'b00, 1'b0, 2'd0, 8'd0);
    for (int k = 0; k < 19; k++) begin
      ldNow = (k == 2) || (k == 5);
      ldDiv = (k == 2) ? 8'd6 : 8'd8;
      applyStimulus(2'b01, ldNow, 2'd0, ldDiv);
      if (k < 10)      expClk = (k < 5);
      else if (k < 18) expClk = ((k - 10) < 4);
      else             expClk = 1'b1;
      checkOutput($sformatf("lw_clk_k%0d", k), clk_out[0], expClk);
      if (ldNow) checkOutput($sformatf("lw_ack_k%0d", k), load_ack, 1'b1);
`ifdef DIVFREQ_TICK_EN
      checkOutput($sformatf("lw_tick_k%0d", k), tick[0], (k == 0) || (k == 10) || (k == 18));
`endif
    end

    $display("[TB] reset while pending");
    applyStimulus(2'b01, 1'b1, 2'd0, 8'd6);
    checkOutput("rp_ack", load_ack, 1'b1);
    checkOutput("rp_high", clk_out[0], 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rp_async_clk", clk_out, 2'b00);
    checkOutput("rp_async_ack", load_ack, 1'b0);
    @(posedge clock50);
    #1;
    checkOutput("rp_held_clk", clk_out, 2'b00);
    @(negedge clock50);
    en     = 2'b00;
    load   = 1'b0;
    reset  = 1'b0;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(2'b01, 1'b0, 2'd0, 8'd0);
      checkOutput($sformatf("rp_clk_k%0d", k), clk_out[0], (k % DEF) < (DEF / 2));
`ifdef DIVFREQ_TICK_EN
      checkOutput($sformatf("rp_tick_k%0d", k), tick[0], (k % DEF) == 0);
`endif
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
